// File: rtl/offchip_memory_if.sv
// Line-sized memory port between the cache controller (master) and off-chip memory (slave).
// mem_err_o exists only when OFFCHIP_RANGE_CHECK_EN is defined.
interface offchip_memory_if;
  logic         mem_enable_i;
  logic         mem_write_i;
  logic [31:0]  mem_addr_i;
  logic [255:0] mem_data_i;
  logic [255:0] mem_data_o;
  logic         mem_ack_o;
  logic         mem_busy_o;
`ifdef OFFCHIP_RANGE_CHECK_EN
  logic         mem_err_o;
`endif

  modport master (
    output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_busy_o
`ifdef OFFCHIP_RANGE_CHECK_EN
    , input mem_err_o
`endif
  );

  modport slave (
    input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_busy_o
`ifdef OFFCHIP_RANGE_CHECK_EN
    , output mem_err_o
`endif
  );
endinterface

// File: rtl/offchip_memory.sv
// Behavioural off-chip line memory: one request at a time, fixed LATENCY, one-cycle ack.
// Define OFFCHIP_RANGE_CHECK_EN to flag and suppress out-of-range line accesses via mem_err_o.
module offchip_memory #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  offchip_memory_if.slave  mem
);
  localparam int           IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [26:0]  DEPTH_L  = 27'(DEPTH);
  localparam logic [7:0]   CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t             r_state, w_next;
  logic [7:0]         r_cnt;
  logic               r_wr;
  logic [IDX_W-1:0]   r_idx;
  logic [255:0]       r_wdata;
  logic [255:0]       r_rdata;
  logic [255:0]       r_mem [DEPTH];

  logic [26:0]        w_line;
  logic [IDX_W-1:0]   w_idx;
  logic               w_commit;
  logic               w_unused;

  assign w_line   = mem.mem_addr_i[31:5];
  assign w_idx    = IDX_W'(w_line % DEPTH_L);
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 8'd0);
  assign w_unused = &{1'b0, mem.mem_addr_i[4:0]};

`ifdef OFFCHIP_RANGE_CHECK_EN
  logic r_oor;
  logic w_wr_en;
  assign w_wr_en       = r_wr && !r_oor;
  assign mem.mem_err_o = (r_state == S_ACK) && r_oor;
`else
  logic w_wr_en;
  assign w_wr_en = r_wr;
`endif

  assign mem.mem_ack_o  = (r_state == S_ACK);
  assign mem.mem_busy_o = (r_state != S_IDLE);
  assign mem.mem_data_o = r_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (mem.mem_enable_i) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 8'd0)    w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef OFFCHIP_RANGE_CHECK_EN
      r_oor   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (mem.mem_enable_i) begin
          r_wr    <= mem.mem_write_i;
          r_idx   <= w_idx;
          r_wdata <= mem.mem_data_i;
          r_cnt   <= CNT_INIT;
`ifdef OFFCHIP_RANGE_CHECK_EN
          r_oor   <= (w_line >= DEPTH_L);
`endif
        end
        S_WAIT: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
          // Write-acks leave the read register untouched
          else if (!r_wr) begin
`ifdef OFFCHIP_RANGE_CHECK_EN
            r_rdata <= r_oor ? '0 : r_mem[r_idx];
`else
            r_rdata <= r_mem[r_idx];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; a reset on the commit edge still drops the write
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_commit && w_wr_en) r_mem[r_idx] <= r_wdata;
  end
endmodule

// File: doc/offchip_memory.md
# offchip_memory

Behavioural off-chip main memory for the cached CPU, sitting directly downstream of the data cache controller on the 256-bit line interface. It accepts one line-sized read or write request at a time, holds it for a fixed access latency, and then completes it with a single-cycle acknowledge. It is the memory side of the `mem_*` port group that the CPU top exposes, and it serves as the testbench memory for the cache.

## Interface
- `DEPTH`, 512: number of 256-bit lines stored.
- `LATENCY`, 10: cycles from request acceptance to `mem_ack_o`; legal range 1..255.
- `clk_i  input  1`: clock; all state updates on rising edge.
- `rst_i  input  1`: reset; one clock, synchronous, active-high.
- `mem_enable_i  input  1`: request valid; sampled only in IDLE.
- `mem_write_i  input  1`: 1 = line write, 0 = line read; captured with the request.
- `mem_addr_i  input  32`: byte address; bits [4:0] ignored (32-byte lines).
- `mem_data_i  input  256`: write line data; captured with the request.
- `mem_data_o  output  256`: read line data; valid in the `mem_ack_o` cycle of a read, held afterwards.
- `mem_ack_o  output  1`: one-cycle completion pulse.
- `mem_busy_o  output  1`: high while a request is outstanding (state ≠ IDLE).

## Operation
- Storage is an array of `DEPTH` × 256 bits. Line index = `mem_addr_i[31:5]` mod `DEPTH`, except as modified by Configuration. Contents are not cleared by reset.
- FSM states:
  - IDLE → WAIT when `mem_enable_i`=1. At this transition, latch write flag, index and write data. Load the counter with `LATENCY`-1.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to ACK. At that same edge:
    - for a write, write the latched data into the array;
    - for a read, register the array line into `mem_data_o`.
  - ACK: `mem_ack_o`=1 for this cycle only. Go to IDLE unconditionally. `mem_enable_i` is ignored in ACK.
- Inputs that change during WAIT or ACK have no effect; the request uses only the values latched at acceptance.
- A write-ack leaves `mem_data_o` unchanged.
- A read of a line written by the immediately preceding request returns the new data.
- `mem_busy_o` is high in WAIT and ACK, and low in IDLE.

## Timing
- Reset values: `mem_ack_o`=0, `mem_busy_o`=0, `mem_data_o`=0, state IDLE, counter 0.
- Request sampled at edge E (state IDLE, enable high): `mem_ack_o` is high during the cycle after edge E+`LATENCY`. Exactly `LATENCY` cycles separate acceptance from ack.
- With `LATENCY`=1, WAIT lasts one cycle and ack follows immediately.
- Back-to-back operation: enable held high through ACK is taken as a new request at the first IDLE edge after ACK. Minimum request period is therefore `LATENCY`+2 cycles.
- Reset asserted in any state: the next edge returns to IDLE.
  - An in-flight write is discarded (array not updated unless the commit edge has already passed).
  - No ack is produced for an aborted request.
  - `mem_data_o` is cleared.
- Reset has priority over every other event on the same edge.

## Configuration
- `OFFCHIP_RANGE_CHECK_EN` defined:
  - Adds output `mem_err_o` (1 bit, reset 0).
  - A request with `mem_addr_i[31:5]` ≥ `DEPTH` still completes with normal latency and ack.
  - Such a write does not modify the array.
  - Such a read returns all zeros on `mem_data_o`.
  - `mem_err_o` is high in the same cycle as that `mem_ack_o` only.
- Not defined:
  - No `mem_err_o` port.
  - The index wraps modulo `DEPTH` (address bits above the index width are dropped).

## Test plan
- Reset, then idle 5 cycles → `mem_ack_o`, `mem_busy_o` and `mem_data_o` stay 0.
- `LATENCY`=10: write `0xA5…A5` to address `0x0000_0400`, then read the same address → each ack arrives exactly 10 cycles after acceptance; read returns `0xA5…A5`; `mem_busy_o` is high 11 cycles per request.
- Accept a read of `0x40`, change `mem_addr_i` to `0x80` and `mem_write_i` to 1 mid-WAIT → read of line 2 completes; no write occurs.
- Hold enable high continuously over two reads → second acceptance occurs on the edge after the ACK cycle; acks are 12 cycles apart.
- Write `0x1234` pattern, then assert `rst_i` 3 cycles after acceptance; read afterwards → no ack for the aborted write; read returns the old line contents.
- `DEPTH`=512, write to `0x0000_4000` (index 512):
  - with `OFFCHIP_RANGE_CHECK_EN` → `mem_err_o` pulses with ack; reading `0x0` returns unchanged data;
  - without it → line 0 is overwritten.
